vrf_ldr_data_mover: RTL and testbench

Responder side of the memory-access controller's VRF load command: accepts a start command (DDR4 source address, VRF destination row, byte count), fetches the data from DDR4 over an AXI4 read master, packs 512-bit beats into 1024-bit VRF rows and writes them into the VRF BRAM. It pulses `done_o` when the last row is written. One instance sits between the controller and one DDR4 AXI port.

---
 rtl/vrf_ldr_data_mover_if.sv | 49 ++++
 rtl/vrf_ldr_data_mover.sv | 233 +++++++++++++++++++++++
 tb/tb_vrf_ldr_data_mover.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vrf_ldr_data_mover_if.sv
// AXI4 read-address / read-data channel bundle between the
// VRF load mover (master) and one DDR4 AXI port (slave).
interface vrf_ldr_data_mover_if #(
   parameter int AW = 36,
   parameter int DW = 512
);

   logic [AW-1:0] m_axi_araddr;
   logic [7:0]    m_axi_arlen;
   logic [2:0]    m_axi_arsize;
   logic [1:0]    m_axi_arburst;
   logic          m_axi_arvalid;
   logic          m_axi_arready;

   logic [DW-1:0] m_axi_rdata;
   logic [1:0]    m_axi_rresp;
   logic          m_axi_rlast;
   logic          m_axi_rvalid;
   logic          m_axi_rready;

   modport master (
      output m_axi_araddr,
      output m_axi_arlen,
      output m_axi_arsize,
      output m_axi_arburst,
      output m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rdata,
      input  m_axi_rresp,
      input  m_axi_rlast,
      input  m_axi_rvalid,
      output m_axi_rready
   );

   modport slave (
      input  m_axi_araddr,
      input  m_axi_arlen,
      input  m_axi_arsize,
      input  m_axi_arburst,
      input  m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rdata,
      output m_axi_rresp,
      output m_axi_rlast,
      output m_axi_rvalid,
      input  m_axi_rready
   );

endinterface

// File: rtl/vrf_ldr_data_mover.sv
// VRF load data mover: fetches DDR4 data over AXI4 reads and
// packs pairs of 512-bit beats into 1024-bit VRF BRAM rows.
module vrf_ldr_data_mover #(
   parameter int DDR4_ADDRWIDTH  = 36,
   parameter int AXI_DATAWIDTH   = 512,
   parameter int VRF_ADDRWIDTH   = 10,
   parameter int VRF_DATAWIDTH   = 1024,
   parameter int MAX_BURST_BEATS = 64
) (
   input  logic                     clk,
   input  logic                     rst,

   input  logic                     start_i,
   input  logic [DDR4_ADDRWIDTH-1:0] src_axi_addr_i,
   input  logic [VRF_ADDRWIDTH-1:0] dst_bram_addr_i,
   input  logic [14:0]              byte_to_trans_i,
   output logic                     done_o,
   output logic                     err_o,
   output logic                     busy_o,

   vrf_ldr_data_mover_if.master     axi,

   output logic                     bram_en_o,
   output logic                     bram_we_o,
   output logic [VRF_ADDRWIDTH-1:0] bram_addr_o,
   output logic [VRF_DATAWIDTH-1:0] bram_din_o
);

   localparam logic [8:0] MAX_B = 9'(MAX_BURST_BEATS);

   localparam logic [DDR4_ADDRWIDTH-1:0] ROW_MASK =
      ~DDR4_ADDRWIDTH'(127);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [DDR4_ADDRWIDTH-1:0] addr_q;
   logic [DDR4_ADDRWIDTH-1:0] addr_d;
   logic [8:0]                beats_left_q;
   logic [8:0]                beats_left_d;
   logic [8:0]                burst_q;
   logic [8:0]                burst_d;
   logic [VRF_ADDRWIDTH-1:0]  row_q;
   logic [VRF_ADDRWIDTH-1:0]  row_d;
   logic                      parity_q;
   logic                      parity_d;
   logic                      err_q;
   logic                      err_d;
   logic [AXI_DATAWIDTH-1:0]  low_q;
   logic [AXI_DATAWIDTH-1:0]  low_d;

   logic                      wr_en_q;
   logic                      wr_en_d;
   logic [VRF_ADDRWIDTH-1:0]  wr_addr_q;
   logic [VRF_ADDRWIDTH-1:0]  wr_addr_d;
   logic [VRF_DATAWIDTH-1:0]  wr_data_q;
   logic [VRF_DATAWIDTH-1:0]  wr_data_d;

   logic                      start_ok;
   logic [8:0]                beats_in;
   logic                      beat_ok;
   logic [6:0]                to_bnd;
   logic [8:0]                burst_c;
   logic [8:0]                burst_m1;

   // command acceptance and per-beat strobes
   always_comb begin
      start_ok = start_i &&
                 (state_q == S_IDLE || state_q == S_DONE);
      beats_in = 9'(byte_to_trans_i >> 6) & 9'h1FE;
      beat_ok  = (state_q == S_DATA) && axi.m_axi_rvalid;
   end

   // burst length: clip to remaining beats, 4 KB page, cap
   always_comb begin
      to_bnd  = 7'd64 - {1'b0, addr_q[11:6]};
      burst_c = beats_left_q;
      if ({2'b00, to_bnd} < burst_c) begin
         burst_c = {2'b00, to_bnd};
      end
      if (MAX_B < burst_c) begin
         burst_c = MAX_B;
      end
      burst_m1 = burst_c - 9'd1;
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = (beats_in == 9'd0) ? S_DONE : S_ADDR;
            end
         end
         S_ADDR: begin
            if (axi.m_axi_arready) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (beat_ok && axi.m_axi_rlast) begin
               state_d = (beats_left_q == 9'd1) ? S_FLUSH : S_ADDR;
            end
         end
         S_FLUSH: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            if (start_ok) begin
               state_d = (beats_in == 9'd0) ? S_DONE : S_ADDR;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state-decoded outputs
   always_comb begin
      axi.m_axi_arvalid = (state_q == S_ADDR);
      axi.m_axi_rready  = (state_q == S_DATA);
      axi.m_axi_arlen   = (state_q == S_ADDR) ? burst_m1[7:0] : 8'd0;
      axi.m_axi_araddr  = addr_q;
      axi.m_axi_arsize  = 3'b110;
      axi.m_axi_arburst = 2'b01;
      busy_o = (state_q == S_ADDR) || (state_q == S_DATA) ||
               (state_q == S_FLUSH);
      done_o = (state_q == S_DONE);
      err_o  = err_q;
   end

   // datapath: command latch, beat packing, row write stage
   always_comb begin
      addr_d       = addr_q;
      beats_left_d = beats_left_q;
      burst_d      = burst_q;
      row_d        = row_q;
      parity_d     = parity_q;
      err_d        = err_q;
      low_d        = low_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;

      if (start_ok) begin
         addr_d       = src_axi_addr_i & ROW_MASK;
         beats_left_d = beats_in;
         row_d        = dst_bram_addr_i;
         parity_d     = 1'b0;
         err_d        = 1'b0;
      end

      if (state_q == S_ADDR && axi.m_axi_arready) begin
         burst_d = burst_c;
      end

      if (beat_ok) begin
         beats_left_d = beats_left_q - 9'd1;
         parity_d     = ~parity_q;
         if (axi.m_axi_rresp != 2'b00) begin
            err_d = 1'b1;
         end
         if (!parity_q) begin
            low_d = axi.m_axi_rdata;
         end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_q;
            wr_data_d = {axi.m_axi_rdata, low_q};
            row_d     = row_q + VRF_ADDRWIDTH'(1);
         end
         if (axi.m_axi_rlast) begin
            addr_d = addr_q + DDR4_ADDRWIDTH'({burst_q, 6'd0});
         end
      end
   end

   // datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q       <= '0;
         beats_left_q <= '0;
         burst_q      <= '0;
         row_q        <= '0;
         parity_q     <= 1'b0;
         err_q        <= 1'b0;
         low_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         addr_q       <= addr_d;
         beats_left_q <= beats_left_d;
         burst_q      <= burst_d;
         row_q        <= row_d;
         parity_q     <= parity_d;
         err_q        <= err_d;
         low_q        <= low_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   // BRAM port driven straight from the write stage
   always_comb begin
      bram_en_o   = wr_en_q;
      bram_we_o   = wr_en_q;
      bram_addr_o = wr_addr_q;
      bram_din_o  = wr_data_q;
   end

endmodule

// File: tb/tb_vrf_ldr_data_mover.sv
// Bench for vrf_ldr_data_mover: AXI slave with a DDR model,
// expected AR/row queues built from byte-level arithmetic.
module tb_vrf_ldr_data_mover;

   localparam int AW   = 36;
   localparam int DW   = 512;
   localparam int VA   = 10;
   localparam int VD   = 1024;
   localparam int MAXB = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [AW-1:0] src_i;
   logic [VA-1:0] dst_i;
   logic [14:0]   bytes_i;
   logic          done_o;
   logic          err_o;
   logic          busy_o;
   logic          bram_en;
   logic          bram_we;
   logic [VA-1:0] bram_addr;
   logic [VD-1:0] bram_din;

   always #5 clk = ~clk;

   vrf_ldr_data_mover_if #(.AW(AW), .DW(DW)) axi ();

   vrf_ldr_data_mover #(
      .DDR4_ADDRWIDTH (AW),
      .AXI_DATAWIDTH  (DW),
      .VRF_ADDRWIDTH  (VA),
      .VRF_DATAWIDTH  (VD),
      .MAX_BURST_BEATS(MAXB)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start_i),
      .src_axi_addr_i (src_i),
      .dst_bram_addr_i(dst_i),
      .byte_to_trans_i(bytes_i),
      .done_o         (done_o),
      .err_o          (err_o),
      .busy_o         (busy_o),
      .axi            (axi),
      .bram_en_o      (bram_en),
      .bram_we_o      (bram_we),
      .bram_addr_o    (bram_addr),
      .bram_din_o     (bram_din)
   );

   typedef struct {
      logic [AW-1:0] a;
      logic [7:0]    len;
   } ar_t;

   typedef struct {
      logic [VA-1:0] row;
      logic [VD-1:0] d;
   } wr_t;

   ar_t exp_ar[$];
   ar_t bursts[$];
   wr_t exp_wr[$];
   int  odd_cyc[$];
   wr_t mw;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_cyc = 0;
   int done_cyc = 0;
   int done_cnt = 0;
   logic err_at_done = 1'b0;
   logic busy_at_done = 1'b0;
   int err_beat = -1;
   int ar_stall = 0;
   int stall_left = 0;
   int gap_pct = 0;
   int gbeat = 0;
   int bk = 0;
   bit hold = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [511:0] obs,
                      input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // DDR content: every 64-B beat address gets a distinct pattern
   function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
      logic [DW-1:0] m;
      logic [31:0]   base;
      base = {2'b00, a[35:6]};
      for (int k = 0; k < 16; k++) begin
         m[32*k +: 32] = (base * 32'h9E3779B1 + 32'(k) * 32'h01000193)
                         ^ 32'hC0FFEE00;
      end
      return m;
   endfunction

   // AXI slave: AR acceptance with stalls, R beats with gaps
   initial begin
      axi.m_axi_arready = 1'b0;
      axi.m_axi_rvalid  = 1'b0;
      axi.m_axi_rdata   = '0;
      axi.m_axi_rresp   = 2'b00;
      axi.m_axi_rlast   = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            axi.m_axi_arready = 1'b0;
            axi.m_axi_rvalid  = 1'b0;
            axi.m_axi_rlast   = 1'b0;
            bursts.delete();
            hold = 1'b0;
            bk = 0;
         end else begin
            if (bursts.size() != 0) begin
               if (!hold) begin
                  if ($urandom_range(0, 99) < gap_pct) begin
                     axi.m_axi_rvalid = 1'b0;
                  end else begin
                     axi.m_axi_rvalid = 1'b1;
                     axi.m_axi_rdata  = mem(bursts[0].a + AW'(64 * bk));
                     axi.m_axi_rlast  = (bk == int'(bursts[0].len));
                     axi.m_axi_rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
                  end
               end
               if (axi.m_axi_rvalid && axi.m_axi_rready) begin
                  if (gbeat % 2 == 1) odd_cyc.push_back(cyc);
                  if (axi.m_axi_rlast) begin
                     last_cyc = cyc;
                     void'(bursts.pop_front());
                     bk = 0;
                  end else begin
                     bk++;
                  end
                  gbeat++;
                  hold = 1'b0;
               end else begin
                  hold = axi.m_axi_rvalid;
               end
            end else begin
               axi.m_axi_rvalid = 1'b0;
               axi.m_axi_rlast  = 1'b0;
            end
            axi.m_axi_arready = 1'b0;
            if (axi.m_axi_arvalid) begin
               chk("ar_pending", exp_ar.size() != 0, 1);
               if (exp_ar.size() != 0) begin
                  chk("araddr", axi.m_axi_araddr, exp_ar[0].a);
                  chk("arlen", axi.m_axi_arlen, exp_ar[0].len);
                  if (stall_left > 0) begin
                     stall_left--;
                  end else begin
                     axi.m_axi_arready = 1'b1;
                     bursts.push_back(exp_ar.pop_front());
                     stall_left = ar_stall;
                  end
               end
            end
         end
      end
   end

   // BRAM and completion monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("bram_we", bram_we, bram_en);
            if (bram_en) begin
               chk("wr_pending", exp_wr.size() != 0, 1);
               if (exp_wr.size() != 0) begin
                  mw = exp_wr.pop_front();
                  chk("bram_addr", bram_addr, mw.row);
                  chk("din_lo", bram_din[511:0], mw.d[511:0]);
                  chk("din_hi", bram_din[1023:512], mw.d[1023:512]);
               end
               chk("wr_src", odd_cyc.size() != 0, 1);
               if (odd_cyc.size() != 0) begin
                  chk("wr_lat", cyc - odd_cyc.pop_front(), 1);
               end
            end
            if (done_o) begin
               done_cnt++;
               done_cyc = cyc;
               err_at_done = err_o;
               busy_at_done = busy_o;
            end
         end
      end
   end

   task automatic launch(input logic [AW-1:0] src,
                         input logic [VA-1:0] dst,
                         input logic [14:0] bytes,
                         input int errb, input int stall,
                         input int gap, output int beats);
      logic [AW-1:0] a;
      logic [AW-1:0] base;
      int rem;
      int b;
      ar_t t;
      wr_t w;
      base = src & ~AW'(127);
      a = base;
      beats = int'(bytes[14:7]) * 2;
      rem = beats;
      while (rem > 0) begin
         b = rem;
         if (64 - int'(a[11:6]) < b) b = 64 - int'(a[11:6]);
         if (MAXB < b) b = MAXB;
         t.a = a;
         t.len = 8'(b - 1);
         exp_ar.push_back(t);
         a = a + AW'(b * 64);
         rem = rem - b;
      end
      for (int i = 0; i < beats / 2; i++) begin
         w.row = dst + VA'(i);
         w.d = {mem(base + AW'(128 * i + 64)), mem(base + AW'(128 * i))};
         exp_wr.push_back(w);
      end
      err_beat = errb;
      ar_stall = stall;
      stall_left = stall;
      gap_pct = gap;
      gbeat = 0;
      @(posedge clk);
      #2;
      start_i = 1'b1;
      src_i = src;
      dst_i = dst;
      bytes_i = bytes;
      @(posedge clk);
      #2;
      start_i = 1'b0;
      src_i = {4'($urandom), 32'($urandom)};
      dst_i = VA'($urandom);
      bytes_i = 15'($urandom);
      if (beats == 0) begin
         chk("zero_done", done_o, 1);
         chk("zero_busy", busy_o, 0);
         chk("zero_arv", axi.m_axi_arvalid, 0);
      end else begin
         chk("busy_c1", busy_o, 1);
         chk("arvalid_c1", axi.m_axi_arvalid, 1);
      end
   endtask

   task automatic run_cmd(input logic [AW-1:0] src,
                          input logic [VA-1:0] dst,
                          input logic [14:0] bytes,
                          input int errb, input int stall,
                          input int gap, input bit pulse);
      int beats;
      int d0;
      int t;
      bit exp_err;
      d0 = done_cnt;
      launch(src, dst, bytes, errb, stall, gap, beats);
      exp_err = (errb >= 0) && (errb < beats);
      t = 0;
      while (done_cnt == d0 && t < 6000) begin
         @(posedge clk);
         #2;
         t++;
         if (pulse && t == 15) start_i = 1'b1;
         if (pulse && t == 16) start_i = 1'b0;
      end
      start_i = 1'b0;
      chk("done_seen", done_cnt - d0, 1);
      if (beats > 0) chk("done_lat", done_cyc - last_cyc, 2);
      chk("err_done", err_at_done, exp_err);
      chk("busy_done", busy_at_done, 0);
      repeat (3) @(posedge clk);
      #2;
      chk("rows_left", exp_wr.size(), 0);
      chk("ars_left", exp_ar.size(), 0);
      chk("done_once", done_cnt - d0, 1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_arvalid", axi.m_axi_arvalid, 0);
      chk("rst_araddr", axi.m_axi_araddr, 0);
      chk("rst_arlen", axi.m_axi_arlen, 0);
      chk("rst_arsize", axi.m_axi_arsize, 3'b110);
      chk("rst_arburst", axi.m_axi_arburst, 2'b01);
      chk("rst_rready", axi.m_axi_rready, 0);
      chk("rst_en", bram_en, 0);
      chk("rst_we", bram_we, 0);
      chk("rst_baddr", bram_addr, 0);
      chk("rst_din", bram_din[511:0] | bram_din[1023:512], 0);
      chk("rst_done", done_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", err_o, 0);
   endtask

   initial begin
      int beats;
      int t;
      int d0;
      int eb;
      rst = 1'b1;
      start_i = 1'b0;
      src_i = '0;
      dst_i = '0;
      bytes_i = '0;
      repeat (3) @(posedge clk);
      #2;
      chk_reset_outputs();
      @(negedge clk);
      rst = 1'b0;

      run_cmd(36'h0_0000_1000, 10'd5, 15'd128, -1, 0, 0, 1'b0);
      run_cmd(36'h0_0000_0F80, 10'd0, 15'd2048, -1, 0, 0, 1'b0);
      run_cmd(36'h0_0000_2000, 10'd7, 15'd0, -1, 0, 0, 1'b0);
      run_cmd(36'h0_0000_3000, 10'd9, 15'd200, -1, 0, 0, 1'b0);
      run_cmd(36'h3_0000_0800, 10'h3F8, 15'd4096, -1, 10, 40, 1'b0);
      run_cmd(36'h0_1234_5600, 10'd20, 15'd512, 3, 0, 20, 1'b0);
      run_cmd(36'h0_1234_5600, 10'd20, 15'd512, -1, 0, 20, 1'b0);
      run_cmd(36'h0_0040_0FC0, 10'd100, 15'd4096, -1, 2, 30, 1'b1);

      launch(36'h0_0050_0000, 10'h100, 15'd4096, -1, 0, 25, beats);
      t = 0;
      while ((exp_wr.size() > 28 || !axi.m_axi_rready) && t < 3000) begin
         @(posedge clk);
         #2;
         t++;
      end
      chk("mid_data", axi.m_axi_rready, 1);
      d0 = done_cnt;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      exp_wr.delete();
      exp_ar.delete();
      odd_cyc.delete();
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_no_done", done_cnt - d0, 0);
      run_cmd(36'h0_0060_0080, 10'd33, 15'd1024, -1, 1, 10, 1'b0);

      for (int i = 0; i < 4; i++) begin
         eb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63)) : -1;
         run_cmd({4'($urandom), 32'($urandom)}, VA'($urandom),
                 15'($urandom_range(0, 4096)), eb,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 50)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
